// File: rtl/if_id_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_id_fetch_stage
//
// Fetch stage and IF/ID pipeline register for the 5-stage RV32I core.
// The stage generates the fetch PC and drives a synchronous instruction
// memory with one cycle of read latency. It captures the returned word
// together with its PC into the ID registers. It also follows the load-use
// stall from the hazard detector and the taken-branch redirect from EX.
// A redirect takes priority over a stall.
//
// Optional feature: define IF_PERF_CNT_EN to build the stall and flush
// performance counters. When the macro is undefined, both counter outputs
// are tied to zero and no counter flops are built.
//
// Ports:
//   clk               core clock, rising edge
//   rst_n             asynchronous active-low reset
//   stall             load-use stall; hold the PC and the IF/ID registers
//   branch_taken_EX   EX resolved a taken branch/jump; redirect and flush
//   branch_target_EX  redirect address (low two bits ignored)
//   imem_en           instruction memory read enable
//   imem_addr         instruction memory read address (the current pc_q)
//   imem_rdata        instruction memory data, valid one cycle after request
//   pc_ID             PC of the instruction held in ID
//   inst_data_ID      instruction held in ID (NOP_INST when empty)
//   valid_ID          ID holds a real instruction
//   bubble_EX         ID/EX must load a bubble this cycle
//   stall_cnt         count of stall cycles (perf counter)
//   flush_cnt         count of redirect cycles (perf counter)
// ---------------------------------------------------------------------------
module if_id_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken_EX,
  input  logic [31:0] branch_target_EX,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_ID,
  output logic [31:0] inst_data_ID,
  output logic        valid_ID,
  output logic        bubble_EX,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] fpc_q, fpc_d;
  logic        fvalid_q, fvalid_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic [31:0] inst_id_q, inst_id_d;
  logic        valid_id_q, valid_id_d;

  // Instructions are word aligned, so the two low target bits are never used.
  logic unused_target_lsbs;
  assign unused_target_lsbs = ^branch_target_EX[1:0];

  // While the stage is stalled, the memory is not re-enabled. Its output
  // register therefore keeps presenting the in-flight word until the stall
  // is released.
  assign imem_addr = pc_q;
  assign imem_en   = !stall && !branch_taken_EX;
  assign bubble_EX = stall && !branch_taken_EX;

  assign pc_ID        = pc_id_q;
  assign inst_data_ID = inst_id_q;
  assign valid_ID     = valid_id_q;

  always_comb begin
    pc_d       = pc_q;
    fpc_d      = fpc_q;
    fvalid_d   = fvalid_q;
    pc_id_d    = pc_id_q;
    inst_id_d  = inst_id_q;
    valid_id_d = valid_id_q;
    if (branch_taken_EX) begin
      // Drop the in-flight fetch. Keep pc_ID so that ID/EX comparisons still
      // see a stable value while ID holds a NOP.
      pc_d       = {branch_target_EX[31:2], 2'b00};
      fvalid_d   = 1'b0;
      inst_id_d  = NOP_INST;
      valid_id_d = 1'b0;
    end else if (!stall) begin
      pc_d     = pc_q + 32'd4;
      fpc_d    = pc_q;
      fvalid_d = 1'b1;
      if (fvalid_q) begin
        pc_id_d    = fpc_q;
        inst_id_d  = imem_rdata;
        valid_id_d = 1'b1;
      end else begin
        inst_id_d  = NOP_INST;
        valid_id_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      fpc_q      <= 32'h0000_0000;
      fvalid_q   <= 1'b0;
      pc_id_q    <= 32'h0000_0000;
      inst_id_q  <= NOP_INST;
      valid_id_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      fpc_q      <= fpc_d;
      fvalid_q   <= fvalid_d;
      pc_id_q    <= pc_id_d;
      inst_id_q  <= inst_id_d;
      valid_id_q <= valid_id_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // A stall that coincides with a redirect counts as a flush, not a stall.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && !branch_taken_EX) stall_cnt_d = stall_cnt_q + 32'd1;
    if (branch_taken_EX)           flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'h0000_0000;
      flush_cnt_q <= 32'h0000_0000;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = 32'h0000_0000;
  assign flush_cnt = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_id_fetch_stage
//
// Directed bench for the fetch stage and the IF/ID register. Each step
// drives stall and redirect inputs, then checks the combinational outputs
// (imem_en, imem_addr, bubble_EX) before the clock edge. Each step also
// pushes the expected ID contents for after the edge, and that entry is
// popped and compared once the edge has passed.
//
// The instruction memory model returns addr*2 one cycle after an enabled
// read. It holds its output when it is not enabled. A second instance,
// built with RESET_PC = FFFF_FFF8, covers the wrap of the fetch address.
// ---------------------------------------------------------------------------
module tb_if_id_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
  } id_exp_t;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken_EX;
  logic [31:0] branch_target_EX;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc_ID;
  logic [31:0] inst_data_ID;
  logic        valid_ID;
  logic        bubble_EX;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  logic        stall2;
  logic        branch2;
  logic [31:0] target2;
  logic        imem_en2;
  logic [31:0] imem_addr2;
  logic [31:0] imem_rdata2;
  logic [31:0] pc_ID2;
  logic [31:0] inst_data_ID2;
  logic        valid_ID2;
  logic        bubble_EX2;
  logic [31:0] stall_cnt2;
  logic [31:0] flush_cnt2;

  int compared;
  int mismatched;
  int exp_stall_cnt;
  int exp_flush_cnt;
  id_exp_t sb[$];

  if_id_fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .branch_taken_EX(branch_taken_EX), .branch_target_EX(branch_target_EX),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .pc_ID(pc_ID), .inst_data_ID(inst_data_ID), .valid_ID(valid_ID),
    .bubble_EX(bubble_EX), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  if_id_fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .NOP_INST(NOP)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .stall(stall2),
    .branch_taken_EX(branch2), .branch_target_EX(target2),
    .imem_en(imem_en2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
    .pc_ID(pc_ID2), .inst_data_ID(inst_data_ID2), .valid_ID(valid_ID2),
    .bubble_EX(bubble_EX2), .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory models: each word is the address times two.
  always @(posedge clk) begin
    if (imem_en)  imem_rdata  <= imem_addr << 1;
    if (imem_en2) imem_rdata2 <= imem_addr2 << 1;
  end

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    id_exp_t e;
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $error("[TB] FAIL %s: scoreboard empty, observed pc %h expected an entry", tag, pc_ID);
    end else begin
      e = sb.pop_front();
      check32({tag, ".pc_ID"}, pc_ID, e.pc);
      check32({tag, ".inst_ID"}, inst_data_ID, e.inst);
      check32({tag, ".valid_ID"}, {31'd0, valid_ID}, {31'd0, e.valid});
    end
  endtask

  // Called one time unit after a rising edge. Drives one cycle of stimulus,
  // checks the combinational outputs, then compares ID after the next edge.
  task automatic applyStimulus(input string tag, input logic s, input logic b,
                               input logic [31:0] tgt, input logic exp_en,
                               input logic [31:0] exp_addr, input logic exp_bubble,
                               input logic [31:0] exp_pc, input logic [31:0] exp_inst,
                               input logic exp_valid);
    id_exp_t e;
    stall            = s;
    branch_taken_EX  = b;
    branch_target_EX = tgt;
    if (s && !b) exp_stall_cnt++;
    if (b)       exp_flush_cnt++;
    #1;
    check32({tag, ".imem_en"}, {31'd0, imem_en}, {31'd0, exp_en});
    check32({tag, ".imem_addr"}, imem_addr, exp_addr);
    check32({tag, ".bubble_EX"}, {31'd0, bubble_EX}, {31'd0, exp_bubble});
    e.pc    = exp_pc;
    e.inst  = exp_inst;
    e.valid = exp_valid;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    exp_stall_cnt = 0;
    exp_flush_cnt = 0;
    rst_n = 1'b0;
    stall = 1'b0;
    branch_taken_EX = 1'b0;
    branch_target_EX = 32'h0;
    stall2 = 1'b0;
    branch2 = 1'b0;
    target2 = 32'h0;
    imem_rdata = 32'h0;
    imem_rdata2 = 32'h0;
    $display("[TB] start");

    repeat (2) @(posedge clk);
    #1;
    check32("rst.pc_ID", pc_ID, 32'h0);
    check32("rst.inst_ID", inst_data_ID, NOP);
    check32("rst.valid_ID", {31'd0, valid_ID}, 32'd0);
    check32("rst.imem_addr", imem_addr, 32'h0);
    check32("rst.stall_cnt", stall_cnt, 32'h0);
    check32("rst.flush_cnt", flush_cnt, 32'h0);
    rst_n = 1'b1;

    // Straight-line fetch; the first instruction reaches ID at edge 2.
    check32("wrap.addr0", imem_addr2, 32'hFFFF_FFF8);
    applyStimulus("A1", 0, 0, 32'h0, 1, 32'h0,  0, 32'h0, NOP,    0);
    check32("wrap.addr1", imem_addr2, 32'hFFFF_FFFC);
    applyStimulus("A2", 0, 0, 32'h0, 1, 32'h4,  0, 32'h0, 32'h0,  1);
    check32("wrap.addr2", imem_addr2, 32'h0000_0000);
    check32("wrap.pc_ID", pc_ID2, 32'hFFFF_FFF8);
    check32("wrap.inst_ID", inst_data_ID2, 32'hFFFF_FFF0);
    applyStimulus("A3", 0, 0, 32'h0, 1, 32'h8,  0, 32'h4, 32'h8,  1);
    applyStimulus("A4", 0, 0, 32'h0, 1, 32'hC,  0, 32'h8, 32'h10, 1);

    // Single stall with pc_ID = 8: ID holds for one extra cycle, then 12 follows.
    applyStimulus("S1", 1, 0, 32'h0, 0, 32'h10, 1, 32'h8,  32'h10, 1);
    applyStimulus("A6", 0, 0, 32'h0, 1, 32'h10, 0, 32'hC,  32'h18, 1);
    applyStimulus("A7", 0, 0, 32'h0, 1, 32'h14, 0, 32'h10, 32'h20, 1);

    // Redirect to 0x103, aligned down to 0x100: two NOP cycles, then the target.
    applyStimulus("B1", 0, 1, 32'h103, 0, 32'h18,  0, 32'h10,  NOP,     0);
    applyStimulus("B2", 0, 0, 32'h0,   1, 32'h100, 0, 32'h10,  NOP,     0);
    applyStimulus("B3", 0, 0, 32'h0,   1, 32'h104, 0, 32'h100, 32'h200, 1);

    // A stall in the same cycle as a redirect: the redirect wins and no bubble is raised.
    applyStimulus("SB1", 1, 1, 32'h40, 0, 32'h108, 0, 32'h100, NOP,     0);
    applyStimulus("SB2", 0, 0, 32'h0,  1, 32'h40,  0, 32'h100, NOP,     0);
    applyStimulus("SB3", 0, 0, 32'h0,  1, 32'h44,  0, 32'h40,  32'h80,  1);

    // Back-to-back stalls raise a bubble in every stalled cycle.
    applyStimulus("SS1", 1, 0, 32'h0, 0, 32'h48, 1, 32'h40, 32'h80, 1);
    applyStimulus("SS2", 1, 0, 32'h0, 0, 32'h48, 1, 32'h40, 32'h80, 1);
    applyStimulus("SS3", 0, 0, 32'h0, 1, 32'h48, 0, 32'h44, 32'h88, 1);

`ifdef IF_PERF_CNT_EN
    check32("perf.stall_cnt", stall_cnt, 32'(exp_stall_cnt));
    check32("perf.flush_cnt", flush_cnt, 32'(exp_flush_cnt));
`else
    check32("perf.stall_cnt", stall_cnt, 32'h0);
    check32("perf.flush_cnt", flush_cnt, 32'h0);
`endif

    // Reset arrives while a stall and a redirect are both pending; nothing survives.
    stall = 1'b1;
    branch_taken_EX = 1'b1;
    branch_target_EX = 32'h300;
    #1;
    rst_n = 1'b0;
    #1;
    check32("mid.imem_addr", imem_addr, 32'h0);
    check32("mid.pc_ID", pc_ID, 32'h0);
    check32("mid.inst_ID", inst_data_ID, NOP);
    check32("mid.valid_ID", {31'd0, valid_ID}, 32'd0);
    check32("mid.stall_cnt", stall_cnt, 32'h0);
    check32("mid.flush_cnt", flush_cnt, 32'h0);
    stall = 1'b0;
    branch_taken_EX = 1'b0;
    branch_target_EX = 32'h0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus("R1", 0, 0, 32'h0, 1, 32'h0, 0, 32'h0, NOP,   0);
    applyStimulus("R2", 0, 0, 32'h0, 1, 32'h4, 0, 32'h0, 32'h0, 1);

    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $error("[TB] FAIL sb.drain: observed %0d leftover entries expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
